nibble_writer8: RTL and testbench

Sequential write-side counterpart to the 8-slot nibble selector in the 7-segment path. Accepts 4-bit digit values over a valid/ready handshake and assembles them into the 32-bit display word: slot k occupies bits [4k+3:4k], and the selector reads from it. Provides an auto-incrementing cursor, direct addressed writes, backspace, and a sweeping clear. Sits between keypad/digit-entry logic and the display mux.

---
 rtl/nibble_writer8_pkg.sv | 28 ++
 rtl/nibble_writer8_slot_decoder3_8.sv | 21 ++
 rtl/nibble_writer8.sv | 155 +++++++++++++++
 tb/tb_nibble_writer8.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_writer8_pkg.sv
// ============================================================================
// nibble_writer8_pkg : shared widths, FSM encoding and helpers for nibble_writer8
// Rev 1.0
// ============================================================================
`default_nettype none

package nibble_writer8_pkg;

  localparam int NIB_W   = 4;
  localparam int SLOTS   = 8;
  localparam int SLOT_AW = 3;

  localparam logic [SLOT_AW-1:0] LAST_SLOT = SLOT_AW'(SLOTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FULL  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // Backspace target: one slot back, saturating at slot 0.
  function automatic logic [SLOT_AW-1:0] cursor_back(input logic [SLOT_AW-1:0] c);
    return (c == '0) ? '0 : c - SLOT_AW'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_writer8_slot_decoder3_8.sv
// ============================================================================
// slot_decoder3_8 : 3-bit slot index + enable to one-hot slot write enable
// Rev 1.0
// ============================================================================
`default_nettype none

module slot_decoder3_8
  import nibble_writer8_pkg::*;
(
  input  logic [SLOT_AW-1:0] idx_i,
  input  logic               en_i,
  output logic [SLOTS-1:0]   onehot_o
);

  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    assign onehot_o[k] = en_i && (idx_i == SLOT_AW'(k));
  end

endmodule

`default_nettype wire

// File: rtl/nibble_writer8.sv
// ============================================================================
// nibble_writer8 : cursor/addressed nibble writer with backspace and sweep clear
// Optional blank_o output enabled by macro NIBBLE_WRITER_BLANK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module nibble_writer8
  import nibble_writer8_pkg::*;
#(
  parameter bit WRAP = 1'b1
)
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [NIB_W-1:0]       wr_data_i,
  input  logic                   wr_addr_en_i,
  input  logic [SLOT_AW-1:0]     wr_addr_i,
  input  logic                   bksp_i,
  input  logic                   clr_i,
  output logic [SLOTS*NIB_W-1:0] word_o,
  output logic [SLOT_AW-1:0]     cursor_o,
  output logic                   full_o,
  output logic                   wr_ack_o
`ifdef NIBBLE_WRITER_BLANK_EN
  ,
  output logic [SLOTS-1:0]       blank_o
`endif
);

  state_e                 state_q, state_d;
  logic [SLOT_AW-1:0]     cursor_q, cursor_d;
  logic [SLOT_AW-1:0]     sweep_q, sweep_d;
  logic [SLOTS*NIB_W-1:0] word_q, word_d;
  logic                   full_q, full_d;
  logic                   ack_q, ack_d;

  logic [SLOT_AW-1:0]     tgt_idx;
  logic                   tgt_en;
  logic                   tgt_zero;
  logic [SLOTS-1:0]       slot_we;

  assign wr_ready_o = (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    sweep_d  = sweep_q;
    ack_d    = 1'b0;
    tgt_idx  = cursor_q;
    tgt_en   = 1'b0;
    tgt_zero = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        tgt_idx  = sweep_q;
        tgt_en   = 1'b1;
        tgt_zero = 1'b1;
        sweep_d  = sweep_q + SLOT_AW'(1);
        if (sweep_q == LAST_SLOT) begin
          cursor_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        // clr beats bksp beats write; losers are simply dropped.
        if (clr_i) begin
          state_d = ST_CLEAR;
          sweep_d = '0;
        end else if (bksp_i) begin
          state_d  = ST_IDLE;
          tgt_en   = 1'b1;
          tgt_zero = 1'b1;
          if (state_q == ST_FULL) begin
            tgt_idx = LAST_SLOT;
          end else begin
            tgt_idx  = cursor_back(cursor_q);
            cursor_d = cursor_back(cursor_q);
          end
        end else if (wr_valid_i && wr_ready_o) begin
          tgt_idx = wr_addr_en_i ? wr_addr_i : cursor_q;
          tgt_en  = 1'b1;
          ack_d   = 1'b1;
          if (!wr_addr_en_i) begin
            if (cursor_q == LAST_SLOT) begin
              if (WRAP) cursor_d = '0;
              else      state_d  = ST_FULL;
            end else begin
              cursor_d = cursor_q + SLOT_AW'(1);
            end
          end
        end
      end
    endcase
    full_d = (state_d == ST_FULL);
  end

  slot_decoder3_8 u_slot_dec (
    .idx_i    (tgt_idx),
    .en_i     (tgt_en),
    .onehot_o (slot_we)
  );

  always_comb begin
    word_d = word_q;
    for (int k = 0; k < SLOTS; k++) begin
      if (slot_we[k]) word_d[k*NIB_W +: NIB_W] = tgt_zero ? '0 : wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cursor_q <= '0;
      sweep_q  <= '0;
      word_q   <= '0;
      full_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      sweep_q  <= sweep_d;
      word_q   <= word_d;
      full_q   <= full_d;
      ack_q    <= ack_d;
    end
  end

  assign word_o   = word_q;
  assign cursor_o = cursor_q;
  assign full_o   = full_q;
  assign wr_ack_o = ack_q;

`ifdef NIBBLE_WRITER_BLANK_EN
  logic [SLOTS-1:0] blank_q, blank_d;

  // A zeroed slot reads as blank; a written slot (even with 0) is shown.
  always_comb begin
    blank_d = blank_q;
    for (int k = 0; k < SLOTS; k++) begin
      if (slot_we[k]) blank_d[k] = tgt_zero;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) blank_q <= '1;
    else         blank_q <= blank_d;
  end

  assign blank_o = blank_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nibble_writer8.sv
// ============================================================================
// tb_nibble_writer8 : two instances (WRAP=1 idx 0, WRAP=0 idx 1) checked
// every cycle against a slot-array model, plus hand-computed checkpoints.
// ============================================================================
`default_nettype none

module tb_nibble_writer8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid[2], aen[2], bksp[2], clr[2];
  logic [3:0]  data[2];
  logic [2:0]  addr[2];
  logic        ready[2], full[2], ack[2];
  logic [31:0] word[2];
  logic [2:0]  cur[2];
`ifdef NIBBLE_WRITER_BLANK_EN
  logic [7:0]  blank[2];
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  nibble_writer8 #(.WRAP(1'b1)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(valid[0]), .wr_ready_o(ready[0]),
    .wr_data_i(data[0]), .wr_addr_en_i(aen[0]), .wr_addr_i(addr[0]),
    .bksp_i(bksp[0]), .clr_i(clr[0]), .word_o(word[0]), .cursor_o(cur[0]),
    .full_o(full[0]), .wr_ack_o(ack[0])
`ifdef NIBBLE_WRITER_BLANK_EN
    , .blank_o(blank[0])
`endif
  );

  nibble_writer8 #(.WRAP(1'b0)) dut_nowrap (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(valid[1]), .wr_ready_o(ready[1]),
    .wr_data_i(data[1]), .wr_addr_en_i(aen[1]), .wr_addr_i(addr[1]),
    .bksp_i(bksp[1]), .clr_i(clr[1]), .word_o(word[1]), .cursor_o(cur[1]),
    .full_o(full[1]), .wr_ack_o(ack[1])
`ifdef NIBBLE_WRITER_BLANK_EN
    , .blank_o(blank[1])
`endif
  );

  // ---------------- behavioural model ----------------
  int m_slot[2][8];
  bit m_blank[2][8];
  int m_cur[2];
  bit m_full[2];
  bit m_clr[2];
  int m_sw[2];
  bit m_ack[2];

  task automatic model_reset(input int d);
    for (int k = 0; k < 8; k++) begin
      m_slot[d][k] = 0;
      m_blank[d][k] = 1'b1;
    end
    m_cur[d] = 0; m_full[d] = 0; m_clr[d] = 0; m_sw[d] = 0; m_ack[d] = 0;
  endtask

  task automatic model_step(input int d);
    int t;
    m_ack[d] = 1'b0;
    if (m_clr[d]) begin
      m_slot[d][m_sw[d]] = 0;
      m_blank[d][m_sw[d]] = 1'b1;
      m_sw[d]++;
      if (m_sw[d] == 8) begin
        m_clr[d] = 1'b0;
        m_cur[d] = 0;
      end
    end else if (clr[d]) begin
      m_clr[d] = 1'b1;
      m_sw[d] = 0;
      m_full[d] = 1'b0;
    end else if (bksp[d]) begin
      if (m_full[d]) m_full[d] = 1'b0;
      else if (m_cur[d] > 0) m_cur[d]--;
      m_slot[d][m_cur[d]] = 0;
      m_blank[d][m_cur[d]] = 1'b1;
    end else if (valid[d] && !m_full[d]) begin
      t = aen[d] ? int'(addr[d]) : m_cur[d];
      m_slot[d][t] = int'(data[d]);
      m_blank[d][t] = 1'b0;
      m_ack[d] = 1'b1;
      if (!aen[d]) begin
        if (m_cur[d] == 7) begin
          if (d == 0) m_cur[d] = 0;
          else        m_full[d] = 1'b1;
        end else begin
          m_cur[d]++;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) model_reset(d);
      else        model_step(d);
    end
  end

  function automatic logic [31:0] exp_word(input int d);
    logic [31:0] w;
    for (int k = 0; k < 8; k++) w[k*4 +: 4] = 4'(m_slot[d][k]);
    return w;
  endfunction

  function automatic logic [31:0] exp_blank(input int d);
    logic [31:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) b[k] = m_blank[d][k];
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("cyc_word[%0d]", d),  word[d], exp_word(d));
        chk($sformatf("cyc_cursor[%0d]", d), 32'(cur[d]), 32'(m_cur[d]));
        chk($sformatf("cyc_full[%0d]", d),  32'(full[d]), 32'(m_full[d]));
        chk($sformatf("cyc_ack[%0d]", d),   32'(ack[d]), 32'(m_ack[d]));
        chk($sformatf("cyc_ready[%0d]", d), 32'(ready[d]), 32'(!m_full[d] && !m_clr[d]));
`ifdef NIBBLE_WRITER_BLANK_EN
        chk($sformatf("cyc_blank[%0d]", d), 32'(blank[d]), exp_blank(d));
`endif
      end
    end
  end

  int ack_cnt[2] = '{0, 0};
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) if (ack[d] === 1'b1) ack_cnt[d]++;
  end

  // ---------------- stimulus ----------------
  task automatic drv(input int d, input bit v, input bit ae, input int a,
                     input int dt, input bit b, input bit c);
    valid[d] = v; aen[d] = ae; addr[d] = 3'(a); data[d] = 4'(dt);
    bksp[d] = b; clr[d] = c;
  endtask

  task automatic cyc(input int d, input bit v, input bit ae, input int a,
                     input int dt, input bit b, input bit c);
    drv(d, v, ae, a, dt, b, c);
    @(negedge clk); #1;
    drv(d, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_vals(input int d);
    chk($sformatf("rst_word[%0d]", d),  word[d], 32'h0);
    chk($sformatf("rst_cursor[%0d]", d), 32'(cur[d]), 32'd0);
    chk($sformatf("rst_full[%0d]", d),  32'(full[d]), 32'd0);
    chk($sformatf("rst_ack[%0d]", d),   32'(ack[d]), 32'd0);
    chk($sformatf("rst_ready[%0d]", d), 32'(ready[d]), 32'd1);
`ifdef NIBBLE_WRITER_BLANK_EN
    chk($sformatf("rst_blank[%0d]", d), 32'(blank[d]), 32'hFF);
`endif
  endtask

  int a0, lows, n;

  initial begin
    for (int d = 0; d < 2; d++) drv(d, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals(0);
    chk_reset_vals(1);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Eight cursor writes 1..8 into both instances.
    for (int i = 1; i <= 8; i++) begin
      drv(0, 1, 0, 0, i, 0, 0);
      drv(1, 1, 0, 0, i, 0, 0);
      @(negedge clk); #1;
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("wrap_word",   word[0], 32'h8765_4321);
    chk("wrap_cursor", 32'(cur[0]), 32'd0);
    chk("wrap_full",   32'(full[0]), 32'd0);
    chk("wrap_acks",   32'(ack_cnt[0]), 32'd8);
    chk("nowrap_full", 32'(full[1]), 32'd1);
    chk("nowrap_ready", 32'(ready[1]), 32'd0);

    // 9th write stalls in FULL, then backspace releases slot 7.
    drv(1, 1, 0, 0, 15, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    drv(1, 0, 0, 0, 0, 0, 0);
    chk("stall_word", word[1], 32'h8765_4321);
    chk("stall_acks", 32'(ack_cnt[1]), 32'd8);
    cyc(1, 0, 0, 0, 0, 1, 0);
    chk("fullbk_full",   32'(full[1]), 32'd0);
    chk("fullbk_word",   word[1], 32'h0765_4321);
    chk("fullbk_cursor", 32'(cur[1]), 32'd7);

    // Cursor to 3, addressed write, then backspace.
    for (int i = 1; i <= 3; i++) cyc(0, 1, 0, 0, i, 0, 0);
    cyc(0, 1, 1, 6, 4'hA, 0, 0);
    chk("addr_word",   word[0], 32'h8A65_4321);
    chk("addr_cursor", 32'(cur[0]), 32'd3);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("bk_word",   word[0], 32'h8A65_4021);
    chk("bk_cursor", 32'(cur[0]), 32'd2);

    // Clear with a write held pending throughout.
    drv(0, 1, 0, 0, 5, 0, 1);
    @(negedge clk); #1;
    drv(0, 1, 0, 0, 5, 0, 0);
    lows = 0;
    n = 0;
    while (ready[0] !== 1'b1 && n < 20) begin
      lows++;
      n++;
      @(negedge clk); #1;
    end
    chk("clr_low_cycles", 32'(lows), 32'd8);
    chk("clr_word",   word[0], 32'h0);
    chk("clr_cursor", 32'(cur[0]), 32'd0);
    @(negedge clk); #1;
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("held_word",   word[0], 32'h0000_0005);
    chk("held_cursor", 32'(cur[0]), 32'd1);
    chk("held_ack",    32'(ack[0]), 32'd1);

    // clr + bksp + write together: only the clear happens.
    a0 = ack_cnt[0];
    cyc(0, 1, 0, 0, 7, 1, 1);
    repeat (10) @(negedge clk);
    #1;
    chk("tri_acks",   32'(ack_cnt[0]), 32'(a0));
    chk("tri_word",   word[0], 32'h0);
    chk("tri_cursor", 32'(cur[0]), 32'd0);

    // bksp + write together: only the backspace happens.
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 2, 0, 0);
    a0 = ack_cnt[0];
    cyc(0, 1, 0, 0, 9, 1, 0);
    @(negedge clk); #1;
    chk("bkwr_word",   word[0], 32'h0000_0001);
    chk("bkwr_cursor", 32'(cur[0]), 32'd1);
    chk("bkwr_acks",   32'(ack_cnt[0]), 32'(a0));

    // Asynchronous reset in the sweep=3 cycle of a clear.
    cyc(0, 1, 0, 0, 3, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals(0);
    chk_reset_vals(1);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
